// File: rtl/page_walker_if.sv
// Request, memory and TLB-insert signals of the page-table walker.
// The master modport is the walker's view; slave is the TLB/memory side.
interface page_walker_if #(
  parameter int SADDR = 64,
  parameter int SPCID = 12
);
  logic             walk_req;
  logic [SADDR-1:0] va;
  logic [SPCID-1:0] pcid;
  logic [SADDR-1:0] root;
  logic             abort;
  logic             walk_busy;
  logic             mem_req;
  logic [SADDR-1:0] mem_addr;
  logic             mem_ack;
  logic [SADDR-1:0] mem_rdata;
  logic             insert;
  logic [SADDR-1:0] pa_out;
  logic [SADDR-1:0] va_out;
  logic [SPCID-1:0] pcid_out;
  logic             fault;

  modport master (
    input  walk_req, va, pcid, root, abort, mem_ack, mem_rdata,
    output walk_busy, mem_req, mem_addr, insert, pa_out, va_out, pcid_out, fault
  );

  modport slave (
    output walk_req, va, pcid, root, abort, mem_ack, mem_rdata,
    input  walk_busy, mem_req, mem_addr, insert, pa_out, va_out, pcid_out, fault
  );
endinterface

// File: rtl/page_walker.sv
// Multi-level page-table walker: on a TLB miss it reads one PTE per level and
// either emits a one-cycle insert with the translated address or a fault pulse.
module page_walker #(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SIDX   = 9,
  parameter int LEVELS = 3,
  parameter int SPCID  = 12
) (
  input  logic           clk,
  input  logic           rst,
  page_walker_if.master  bus
);

  localparam int SPPN = SADDR - SPAGE;
  localparam int SLVL = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [SLVL-1:0] LAST_LVL = SLVL'(LEVELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WALK  = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd2;
  localparam logic [2:0] S_FAULT = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state_q;
  logic [SLVL-1:0]  level_q;
  logic [SPPN-1:0]  base_q;
  logic [SPPN-1:0]  leaf_ppn_q;
  logic [SADDR-1:0] va_q;
  logic [SPCID-1:0] pcid_q;

  logic [SIDX-1:0]  idx;
  logic             pte_v;
  logic             pte_l;
  logic [SPPN-1:0]  pte_ppn;

  assign pte_v   = bus.mem_rdata[0];
  assign pte_l   = bus.mem_rdata[1];
  assign pte_ppn = bus.mem_rdata[SADDR-1:SPAGE];

  // Level 0 consumes the most significant index field of the VA.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (level_q == SLVL'(i))
        idx = va_q[SPAGE + SIDX*(LEVELS-i) - 1 -: SIDX];
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      base_q     <= '0;
      leaf_ppn_q <= '0;
      va_q       <= '0;
      pcid_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.walk_req && !bus.abort) begin
            va_q    <= bus.va;
            pcid_q  <= bus.pcid;
            base_q  <= bus.root[SADDR-1:SPAGE];
            level_q <= '0;
            state_q <= S_WALK;
          end
        end
        S_WALK: begin
          if (bus.abort) begin
            // An outstanding read must complete before the walker can go idle.
            state_q <= bus.mem_ack ? S_IDLE : S_DRAIN;
          end else if (bus.mem_ack) begin
            if (!pte_v) begin
              state_q <= S_FAULT;
            end else if (level_q == LAST_LVL) begin
              if (pte_l) begin
                leaf_ppn_q <= pte_ppn;
                state_q    <= S_DONE;
              end else begin
                state_q <= S_FAULT;
              end
            end else if (pte_l) begin
              state_q <= S_FAULT;
            end else begin
              level_q <= level_q + 1'b1;
              base_q  <= pte_ppn;
            end
          end
        end
        S_DRAIN: begin
          if (bus.mem_ack)
            state_q <= S_IDLE;
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAULT: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.walk_busy = (state_q != S_IDLE);
  assign bus.mem_req   = (state_q == S_WALK) || (state_q == S_DRAIN);
  assign bus.mem_addr  = {base_q, idx, 3'b000};
  assign bus.insert    = (state_q == S_DONE);
  assign bus.fault     = (state_q == S_FAULT);
  assign bus.pa_out    = {leaf_ppn_q, va_q[SPAGE-1:0]};
  assign bus.va_out    = va_q;
  assign bus.pcid_out  = pcid_q;

endmodule

// File: tb/tb_page_walker.sv
// Bench for page_walker: directed walks plus randomized page tables, checked
// against a behavioural walk model working on a sparse PTE memory.
module tb_page_walker;

  localparam int SADDR  = 64;
  localparam int SPAGE  = 12;
  localparam int SIDX   = 9;
  localparam int LEVELS = 3;
  localparam int SPCID  = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  page_walker_if #(.SADDR(SADDR), .SPCID(SPCID)) bus ();

  page_walker #(
    .SADDR(SADDR), .SPAGE(SPAGE), .SIDX(SIDX), .LEVELS(LEVELS), .SPCID(SPCID)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] pt_mem [logic [63:0]];
  logic [63:0] exp_addr_q [$];
  bit          exp_ok;
  logic [63:0] exp_pa;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pt_read(input logic [63:0] a);
    return pt_mem.exists(a) ? pt_mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] pte_addr(input logic [63:0] base, input logic [63:0] v, input int lvl);
    return (base & ~64'hFFF) + (((v >> (SPAGE + SIDX*(LEVELS-1-lvl))) & 64'h1FF) << 3);
  endfunction

  // Reference walk: list of reads issued and the final translation, if any.
  task automatic model_walk(input logic [63:0] v, input logic [63:0] rt);
    logic [63:0] base, a, pte;
    exp_addr_q.delete();
    exp_ok = 1'b0;
    exp_pa = 64'h0;
    base   = rt;
    for (int i = 0; i < LEVELS; i++) begin
      a = pte_addr(base, v, i);
      exp_addr_q.push_back(a);
      pte = pt_read(a);
      if (!pte[0]) break;
      if (i == LEVELS-1) begin
        if (pte[1]) begin
          exp_ok = 1'b1;
          exp_pa = (pte & ~64'hFFF) | (v & 64'hFFF);
        end
        break;
      end
      if (pte[1]) break;
      base = pte;
    end
  endtask

  task automatic build_random(output logic [63:0] v, output logic [63:0] rt);
    logic [63:0] base, a, pte;
    int r;
    pt_mem.delete();
    v    = {$urandom, $urandom};
    rt   = {$urandom, $urandom};
    base = rt;
    for (int i = 0; i < LEVELS; i++) begin
      a      = pte_addr(base, v, i);
      r      = $urandom_range(0, 9);
      pte    = {$urandom, $urandom};
      pte[0] = (r != 0);
      pte[1] = (i == LEVELS-1) ? (r != 1) : (r == 1);
      pt_mem[a] = pte;
      if (r < 2) break;
      base = pte;
    end
  endtask

  task automatic build_clean();
    pt_mem.delete();
    pt_mem[64'h1008] = 64'h2001;
    pt_mem[64'h2008] = 64'h3001;
    pt_mem[64'h3018] = 64'h8000_0003;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " walk_busy"}, 64'(bus.walk_busy), 64'h0);
    check({tag, " mem_req"},   64'(bus.mem_req),   64'h0);
    check({tag, " insert"},    64'(bus.insert),    64'h0);
    check({tag, " fault"},     64'(bus.fault),     64'h0);
    check({tag, " mem_addr"},  bus.mem_addr,       64'h0);
    check({tag, " pa_out"},    bus.pa_out,         64'h0);
    check({tag, " va_out"},    bus.va_out,         64'h0);
    check({tag, " pcid_out"},  64'(bus.pcid_out),  64'h0);
  endtask

  // Runs one walk acting as the memory; the walk_req cycle is cycle 1.
  task automatic do_walk(input string tag, input logic [63:0] v, input logic [63:0] rt,
                         input logic [SPCID-1:0] pc, input int waits, input int abort_read,
                         input int abort_at, input bit spam, output int end_cyc);
    logic [63:0] obs_q [$];
    logic [63:0] cur_addr;
    int  cyc, nread, wcnt, n_exp;
    bit  fin, saw_ins, saw_flt, exp_abort;
    cur_addr = '0;
    cyc = 1; nread = 0; wcnt = 0;
    fin = 0; saw_ins = 0; saw_flt = 0;
    model_walk(v, rt);
    exp_abort = (abort_read >= 0) && (abort_read < exp_addr_q.size());
    if (exp_abort) begin
      exp_ok = 1'b0;
      while (exp_addr_q.size() > abort_read + 1) void'(exp_addr_q.pop_back());
    end
    n_exp = exp_addr_q.size();

    @(negedge clk);
    bus.walk_req = 1'b1; bus.va = v; bus.root = rt; bus.pcid = pc;
    bus.abort = 1'b0; bus.mem_ack = 1'b0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.walk_req  = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (spam) bus.va = {$urandom, $urandom};
      bus.abort     = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      if (bus.insert && bus.fault)
        check({tag, " insert_and_fault"}, 64'h1, 64'h0);
      if (bus.insert || bus.fault || !bus.walk_busy) begin
        fin = 1; saw_ins = bus.insert; saw_flt = bus.fault;
        check({tag, " mem_req_at_end"}, 64'(bus.mem_req), 64'h0);
      end else if (bus.mem_req) begin
        if (wcnt == 0) begin
          cur_addr = bus.mem_addr;
          obs_q.push_back(cur_addr);
        end else begin
          check({tag, " addr_stable"}, bus.mem_addr, cur_addr);
        end
        if (nread == abort_read && wcnt == abort_at) bus.abort = 1'b1;
        if (wcnt == waits) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = pt_read(cur_addr);
          nread++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
    end_cyc = cyc;
    bus.walk_req = 1'b0; bus.abort = 1'b0; bus.mem_ack = 1'b0;

    check({tag, " terminated"}, 64'(fin), 64'h1);
    check({tag, " end_cycle"}, 64'(cyc), 64'(2 + n_exp*(waits+1)));
    check({tag, " insert"}, 64'(saw_ins), 64'(exp_ok));
    check({tag, " fault"},  64'(saw_flt), 64'(!exp_ok && !exp_abort));
    check({tag, " n_reads"}, 64'(obs_q.size()), 64'(n_exp));
    for (int i = 0; i < obs_q.size() && i < n_exp; i++)
      check($sformatf("%s read%0d addr", tag, i), obs_q[i], exp_addr_q[i]);
    check({tag, " va_out"},   bus.va_out,        v);
    check({tag, " pcid_out"}, 64'(bus.pcid_out), 64'(pc));
    if (exp_ok) check({tag, " pa_out"}, bus.pa_out, exp_pa);

    @(negedge clk);
    check({tag, " idle_after"},   64'(bus.walk_busy), 64'h0);
    check({tag, " insert_after"}, 64'(bus.insert),    64'h0);
    check({tag, " fault_after"},  64'(bus.fault),     64'h0);
  endtask

  initial begin
    logic [63:0] v, rt;
    int ec;

    rst = 1'b1;
    bus.walk_req = 1'b0; bus.va = '0; bus.pcid = '0; bus.root = '0;
    bus.abort = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean three-level walk, zero-wait memory.
    build_clean();
    do_walk("clean", 64'h4020_3ABC, 64'h1000, 12'h05A, 0, -1, 0, 0, ec);
    check("clean insert_cycle", 64'(ec), 64'd5);
    check("clean pa_literal", bus.pa_out, 64'h8000_0ABC);

    // Invalid level-1 PTE.
    pt_mem[64'h2008] = 64'h3000;
    do_walk("fault_l1", 64'h4020_3ABC, 64'h1000, 12'h123, 0, -1, 0, 0, ec);
    check("fault_l1 fault_cycle", 64'(ec), 64'd4);

    // Leaf at level 0.
    build_clean();
    pt_mem[64'h1008] = 64'h2003;
    do_walk("early_leaf", 64'h4020_3ABC, 64'h1000, 12'h001, 0, -1, 0, 0, ec);

    // Three wait cycles per read, walk_req noise during the walk.
    build_clean();
    do_walk("waits", 64'h4020_3ABC, 64'h1000, 12'h777, 3, -1, 0, 1, ec);
    check("waits insert_cycle", 64'(ec), 64'd14);

    // Abort while waiting on the level-1 read, then a normal walk.
    do_walk("abort_drain", 64'h4020_3ABC, 64'h1000, 12'h0AA, 3, 1, 1, 0, ec);
    do_walk("after_abort", 64'h4020_3ABC, 64'h1000, 12'h0BB, 0, -1, 0, 0, ec);
    check("after_abort insert_cycle", 64'(ec), 64'd5);

    // Abort coinciding with the ack goes straight to idle.
    do_walk("abort_ack", 64'h4020_3ABC, 64'h1FFF, 12'h0CC, 2, 1, 2, 0, ec);

    // Abort in idle blocks acceptance.
    @(negedge clk);
    bus.walk_req = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.walk_req = 1'b0; bus.abort = 1'b0;
    check("abort_idle busy", 64'(bus.walk_busy), 64'h0);
    check("abort_idle mem_req", 64'(bus.mem_req), 64'h0);

    // Reset in the middle of a walk.
    @(negedge clk);
    bus.walk_req = 1'b1; bus.va = 64'h4020_3ABC; bus.root = 64'h1000; bus.pcid = 12'h321;
    @(negedge clk);
    bus.walk_req = 1'b0;
    @(negedge clk);
    check("rst_mid mem_req_before", 64'(bus.mem_req), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    build_clean();
    do_walk("post_reset", 64'h4020_3ABC, 64'h1000, 12'h05A, 0, -1, 0, 0, ec);
    check("post_reset insert_cycle", 64'(ec), 64'd5);
    check("post_reset pa_literal", bus.pa_out, 64'h8000_0ABC);

    // Randomized page tables, wait states, aborts and request noise.
    for (int n = 0; n < 40; n++) begin
      int w, ar, aa;
      build_random(v, rt);
      w  = $urandom_range(0, 3);
      ar = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LEVELS-1) : -1;
      aa = $urandom_range(0, w);
      do_walk($sformatf("rand%0d", n), v, rt, SPCID'($urandom), w, ar, aa,
              1'($urandom_range(0, 1)), ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 Parameter SADDR, 64, address and PTE width in bits.
REQ-002 Parameter SPAGE, 12, page-offset width; SIDX+3 SHALL equal SPAGE.
REQ-003 Parameter SIDX, 9, VA index bits per level.
REQ-004 Parameter LEVELS, 3, table levels; level 0 is the root.
REQ-005 Parameter SPCID, 12, process-context identifier width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 walk_req  in  1  start a walk; TLB miss indication.
REQ-009 va  in  SADDR  virtual address to translate.
REQ-010 pcid  in  SPCID  context of the request.
REQ-011 root  in  SADDR  root table physical base; bits [SPAGE-1:0] are ignored.
REQ-012 abort  in  1  cancel the current walk; TLB shutdown.
REQ-013 walk_busy  out  1  high in every state except IDLE.
REQ-014 mem_req  out  1  PTE read request.
REQ-015 mem_addr  out  SADDR  PTE physical address.
REQ-016 mem_ack  in  1  read complete; mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  in  SADDR  PTE: bit0 V, bit1 L (leaf), [SADDR-1:SPAGE] PPN.
REQ-018 insert  out  1  one-cycle pulse; pa_out, va_out and pcid_out are valid.
REQ-019 pa_out  out  SADDR  {leaf PPN, va_out[SPAGE-1:0]}; feeds the TLB pa input.
REQ-020 va_out, pcid_out  out  SADDR, SPCID  latched request, held until the next accepted walk.
REQ-021 fault  out  1  one-cycle pulse when a walk terminates invalidly.

Function
REQ-022 FSM states SHALL be IDLE, WALK, DONE, FAULT and DRAIN.
REQ-023 In IDLE, walk_req=1 with abort=0 SHALL latch va, pcid and root, set level=0, and enter WALK.
REQ-024 walk_req SHALL be ignored outside IDLE; there is no queueing.
REQ-025 At level i, the index SHALL be va[SPAGE+SIDX*(LEVELS-i)-1 : SPAGE+SIDX*(LEVELS-1-i)].
REQ-026 mem_addr SHALL be {base[SADDR-1:SPAGE], index, 3'b000}; base is root at level 0, otherwise the previous PTE PPN.
REQ-027 mem_req SHALL be 1 throughout WALK; mem_addr SHALL stay stable until the edge at which mem_ack=1.
REQ-028 On an ack edge, the FSM SHALL act on the PTE as follows:
- V=0: go to FAULT.
- L=1 with level<LEVELS-1: go to FAULT.
- L=0 with level=LEVELS-1: go to FAULT.
- L=1 with level=LEVELS-1: latch the PPN and go to DONE.
- Otherwise: increment level, load the new base, and stay in WALK; mem_req stays 1 with the new address in the next cycle.
REQ-029 DONE SHALL assert insert for exactly one cycle, then return to IDLE.
REQ-030 FAULT SHALL assert fault for exactly one cycle, then return to IDLE.
REQ-031 Minimum latency SHALL be LEVELS+2 cycles from the walk_req edge to the insert cycle (zero-wait ack); each ack wait cycle adds one.
REQ-032 abort in IDLE SHALL block acceptance of walk_req in that cycle.
REQ-033 abort in WALK with mem_ack=0 SHALL enter DRAIN; DRAIN keeps mem_req/mem_addr until ack, then goes to IDLE with no insert and no fault.
REQ-034 abort in WALK with mem_ack=1 SHALL go directly to IDLE.
REQ-035 abort in DONE or FAULT SHALL NOT suppress the pending pulse.
REQ-036 mem_ack outside WALK/DRAIN SHALL be ignored.
REQ-037 insert and fault SHALL never be high in the same cycle.

Reset
REQ-038 rst=1 SHALL force IDLE and clear walk_busy, mem_req, insert, fault, mem_addr, pa_out, va_out and pcid_out to 0.
REQ-039 rst has priority over all inputs; reset mid-WALK drops mem_req in the next cycle, and the memory side tolerates an abandoned read.

Verification
REQ-040 Clean walk: root=0x1000, va=0x40203ABC, zero-wait ack with PTEs 0x2001, 0x3001, 0x80000003 -> mem_addr sequence 0x1008, 0x2008, 0x3018; insert in cycle 5 with pa_out=0x80000ABC.
REQ-041 Fault: the same walk with level-1 PTE=0x3000 -> fault pulse after the second ack; no insert; third read never issued.
REQ-042 Early leaf: level-0 PTE=0x2003 -> fault; walk_busy low on the next cycle.
REQ-043 Wait states: ack delayed 3 cycles on each level -> mem_addr stable while waiting; insert in cycle 14; walk_req pulses during the walk are ignored.
REQ-044 Abort: abort asserted while waiting for the level-1 ack -> mem_req held until ack, then IDLE; insert=fault=0 throughout; the next walk_req is accepted normally.
REQ-045 Reset: rst asserted mid-WALK -> all outputs 0 on the next cycle; a following clean walk matches REQ-040.
